// File: rtl/instruction_fetch_pkg.sv
// Shared constants for the instruction fetch stage: word width, reset/halt defaults
// and the bubble word.
package instruction_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [5:0] HALT_OPCODE_DEFAULT = 6'b111111;
  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/instruction_fetch_pc_reg.sv
// Program counter register with its next-PC mux.
// Priority: reset, redirect (branch over jump), hold, sequential advance.
module pc_reg
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            hold,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump,
  input  logic [XLEN-1:0] jump_target,
  output logic [XLEN-1:0] pc
);

  logic [XLEN-1:0] redirect_pc;

  always_comb begin
    redirect_pc = word_align(jump_target);
    if (branch_taken) begin
      redirect_pc = word_align(branch_target);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (branch_taken || jump) begin
      pc <= redirect_pc;
    end else if (!hold) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: drives the PC to instruction memory and registers the
// returned word into the IF/ID register, with halt detection and a fetch counter.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC    = RESET_PC_DEFAULT,
  parameter logic [5:0]      HALT_OPCODE = HALT_OPCODE_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_data,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic        halted,
  output logic [31:0] fetch_count
);

  logic [XLEN-1:0] pc_p0;
  logic [XLEN-1:0] instr_p1;
  logic [XLEN-1:0] pc4_p1;
  logic            vld_p1;
  logic            halted_q;
  logic [XLEN-1:0] fetch_count_q;
  logic            redirect;

  assign redirect = branch_taken | jump;

  pc_reg #(
    .RESET_PC(RESET_PC)
  ) u_pc_reg (
    .clk          (clk),
    .rst          (rst),
    .hold         (halted_q | stall),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .jump         (jump),
    .jump_target  (jump_target),
    .pc           (pc_p0)
  );

  assign imem_addr = pc_p0;

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      instr_p1      <= NOP_WORD;
      pc4_p1        <= '0;
      vld_p1        <= 1'b0;
      halted_q      <= 1'b0;
      fetch_count_q <= '0;
    end else if (redirect) begin
      instr_p1 <= NOP_WORD;
      vld_p1   <= 1'b0;
      halted_q <= 1'b0;
    end else if (halted_q) begin
      vld_p1 <= 1'b0;
    end else if (!stall) begin
      instr_p1      <= imem_data;
      pc4_p1        <= pc_p0 + PC_STEP;
      vld_p1        <= 1'b1;
      fetch_count_q <= fetch_count_q + 32'd1;
      // The halt word itself is delivered as a valid instruction before fetch freezes.
      if (imem_data[31:26] == HALT_OPCODE) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign if_id_instr = instr_p1;
  assign if_id_pc4   = pc4_p1;
  assign if_id_valid = vld_p1;
  assign halted      = halted_q;
  assign fetch_count = fetch_count_q;

endmodule
